output_drain: RTL and testbench
===============================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the element width in bits (int32).
REQ-002 SHALL have parameter SYSTOLIC_ARRAY_WIDTH (W), default 16, the tile edge and the vector length.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, the output-buffer address width.
REQ-004 SHALL have the following ports, with clock and reset first:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to drain one WxW tile.
- base_addr  in  ADDR_WIDTH  address of the tile's first column vector.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.
- buf_rd_en  out  1  output-buffer read enable.
- buf_rd_addr  out  ADDR_WIDTH  output-buffer read address.
- buf_rd_data  in  signed DATA_WIDTH x [W]  column vector, valid 1 cycle after buf_rd_en.
- m_valid  out  1  row beat valid.
- m_ready  in  1  downstream AXI-master ready.
- m_data  out  signed DATA_WIDTH x [W]  row vector; m_data[j] = tile column j, current row.
- m_last  out  1  high on row W-1.

Function
REQ-005 SHALL implement the states IDLE, FILL, DRAIN and DONE.
REQ-006 SHALL leave IDLE for FILL when start=1 is sampled in IDLE, latching base_addr at that edge.
REQ-007 SHALL ignore start in every state other than IDLE.
REQ-008 SHALL, in FILL, assert buf_rd_en for exactly W consecutive cycles.
REQ-009 SHALL drive buf_rd_addr = base_addr+k on read k (k=0..W-1), computed modulo 2^ADDR_WIDTH so the address wraps.
REQ-010 SHALL capture buf_rd_data one cycle after read k into tile column k, giving tile[r][k] = buf_rd_data[r].
REQ-011 SHALL enter DRAIN on the edge that captures column W-1, so FILL lasts W+1 cycles.
REQ-012 SHALL assert m_valid first W+2 cycles after the start edge.
REQ-013 SHALL, in DRAIN, hold m_valid=1 and drive m_data[j] = tile[r][j] for the current row counter r, starting at r=0.
REQ-014 SHALL advance r only when m_valid && m_ready.
REQ-015 SHALL keep m_data and m_last stable while m_valid && !m_ready.
REQ-016 SHALL, when row W-1 is accepted, enter DONE for one cycle with done=1 and then return to IDLE.
REQ-017 SHALL keep m_valid=0 in IDLE, FILL and DONE.
REQ-018 SHALL keep buf_rd_en=0 outside FILL.
REQ-019 SHALL handle m_ready held at 1: one row per cycle, so DRAIN lasts W cycles.
REQ-020 SHALL handle m_ready held at 0: wait indefinitely with no timeout.
REQ-021 SHALL accept a start asserted in the DONE cycle as ignored; the earliest accepted restart is the first IDLE cycle.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronous assertion, including mid-FILL or mid-DRAIN), force the state to IDLE, all counters to 0, and busy, done, buf_rd_en, m_valid and m_last to 0.
REQ-023 SHALL reset buf_rd_addr to 0.
REQ-024 SHALL not reset tile contents or m_data, which are don't-care while m_valid=0.
REQ-025 SHALL resume normal operation on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL provide macro OUTPUT_DRAIN_STALL_CNT_EN; when it is defined, the module SHALL add output port stall_cycles (out, 32) counting cycles with m_valid && !m_ready.
REQ-027 SHALL, when OUTPUT_DRAIN_STALL_CNT_EN is defined, clear stall_cycles to 0 on reset and on an accepted start, and saturate it at 2^32-1.
REQ-028 SHALL, when OUTPUT_DRAIN_STALL_CNT_EN is undefined, omit the port and the counter, with all other behaviour identical.

Structure
REQ-029 SHALL place the state enum (IDLE, FILL, DRAIN, DONE) and the default DATA_WIDTH, SYSTOLIC_ARRAY_WIDTH and ADDR_WIDTH constants in the shared package tpu_pkg.
REQ-030 SHALL be single-level except for one natural sub-module, output_drain_tile_reg (the WxW register tile with column write and row read).

Verification
REQ-031 Transpose: W=16, base_addr=0x020, mem[0x020+c][i]=c*16+i, m_ready=1 -> beat r has m_data[j]=j*16+r, m_last only on beat 15, done 1 cycle after beat 15.
REQ-032 Wrap: base_addr=0x3F8 -> buf_rd_addr sequence 0x3F8..0x3FF,0x000..0x007; data transposed correctly.
REQ-033 Backpressure: m_ready=0 for the first 5 DRAIN cycles, then toggled 1/0 -> rows 0..15 each delivered exactly once, m_data stable while stalled; stall_cycles equals the number of stalled cycles when the macro is defined.
REQ-034 Start ignored: start pulsed during FILL and during DRAIN -> no extra reads, exactly 16 beats, a single done.
REQ-035 Reset mid-DRAIN: rst_n=0 after row 7 is accepted -> m_valid, busy and buf_rd_en are 0 immediately; a new start gives a full 16-beat tile.
REQ-036 Latency: start at cycle 0 -> buf_rd_en high for cycles 1..16, first m_valid at cycle 18.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types and default dimensions
package tpu_pkg;
  localparam int DEF_DATA_WIDTH           = 32;
  localparam int DEF_SYSTOLIC_ARRAY_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH           = 10;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} drain_state_t;
endpackage

// File: rtl/output_drain_tile_reg.sv
// rtl/output_drain_tile_reg.sv - WxW register tile, written one column per cycle, read one row
module output_drain_tile_reg #(
  parameter int DATA_WIDTH           = 32,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int IW                   = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [IW-1:0]                wr_col,
  input  logic signed [DATA_WIDTH-1:0] wr_data [SYSTOLIC_ARRAY_WIDTH],
  input  logic [IW-1:0]                rd_row,
  output logic signed [DATA_WIDTH-1:0] rd_data [SYSTOLIC_ARRAY_WIDTH]
);
  logic signed [DATA_WIDTH-1:0] tile [SYSTOLIC_ARRAY_WIDTH][SYSTOLIC_ARRAY_WIDTH];

  // Contents are don't-care until a fill completes, so the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < SYSTOLIC_ARRAY_WIDTH; r++) begin
        tile[r][wr_col] <= wr_data[r];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < SYSTOLIC_ARRAY_WIDTH; j++) begin
      rd_data[j] = tile[rd_row][j];
    end
  end
endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - reads a WxW tile as column vectors and streams it out transposed as rows
// Optional OUTPUT_DRAIN_STALL_CNT_EN adds the stall_cycles output.
module output_drain
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int SYSTOLIC_ARRAY_WIDTH = DEF_SYSTOLIC_ARRAY_WIDTH,
  parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         buf_rd_en,
  output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] buf_rd_data [SYSTOLIC_ARRAY_WIDTH],
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data [SYSTOLIC_ARRAY_WIDTH],
  output logic                         m_last
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);
  localparam int              IW       = $clog2(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(SYSTOLIC_ARRAY_WIDTH - 1);
  localparam logic [IW:0]     RD_TOTAL = (IW + 1)'(SYSTOLIC_ARRAY_WIDTH);

  drain_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IW:0]           rd_cnt_q;
  logic                  cap_vld_q;
  logic [IW-1:0]         cap_col_q;
  logic [IW-1:0]         row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_cnt_q  <= '0;
      cap_vld_q <= 1'b0;
      cap_col_q <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      // Read data returns one cycle after the request, so the column index trails the read count.
      cap_vld_q <= buf_rd_en;
      cap_col_q <= rd_cnt_q[IW-1:0];
      if (state_q == IDLE && start) begin
        base_q   <= base_addr;
        rd_cnt_q <= '0;
        row_q    <= '0;
      end
      if (buf_rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (m_valid && m_ready) row_q <= row_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    buf_rd_en = 1'b0;
    m_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FILL;
      end
      FILL: begin
        buf_rd_en = (rd_cnt_q < RD_TOTAL);
        if (cap_vld_q && cap_col_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (m_ready && row_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign buf_rd_addr = base_q + ADDR_WIDTH'(rd_cnt_q);
  assign m_last      = m_valid && (row_q == LAST_IDX);

  output_drain_tile_reg #(
    .DATA_WIDTH          (DATA_WIDTH),
    .SYSTOLIC_ARRAY_WIDTH(SYSTOLIC_ARRAY_WIDTH),
    .IW                  (IW)
  ) u_tile (
    .clk    (clk),
    .wr_en  (cap_vld_q),
    .wr_col (cap_col_q),
    .wr_data(buf_rd_data),
    .rd_row (row_q),
    .rd_data(m_data)
  );

`ifdef OUTPUT_DRAIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (state_q == IDLE && start) begin
      stall_cycles <= '0;
    end else if (m_valid && !m_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - randomized bench for output_drain against a transpose model
module tb_output_drain;
  localparam int DW = 32;
  localparam int W  = 16;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic                 busy, done, buf_rd_en, m_valid, m_last;
  logic                 m_ready = 1'b0;
  logic [AW-1:0]        buf_rd_addr;
  logic signed [DW-1:0] buf_rd_data [W];
  logic signed [DW-1:0] m_data [W];
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
  logic [31:0]          stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] mem [1 << AW][W];

  output_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Output buffer: data appears one cycle after the read request.
  always @(posedge clk) begin
    if (buf_rd_en) begin
      for (int i = 0; i < W; i++) buf_rd_data[i] <= mem[buf_rd_addr][i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, buf_rd_en, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_rd_addr"}, buf_rd_addr, '0);
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    check({tag, "_stall"}, stall_cycles, '0);
`endif
  endtask

  // Called and returns at posedge+1. mode: 0 ready=1, 1 five stalls then toggle, 2 random.
  task automatic run_tile(input logic [AW-1:0] base, input bit seq, input int mode,
                          input bit poke, input int abort_at);
    int nreads = 0, beats = 0, drain_cyc = 0, dones = 0, stalls = 0;
    int done_c = -1, acc_c = -1;
    bit fin = 0;
    for (int c = 0; c < W; c++)
      for (int i = 0; i < W; i++)
        mem[AW'(base + c)][i] = seq ? DW'(c * 16 + i) : DW'($urandom);
    base_addr = base;
    start     = 1'b1;
    m_ready   = (mode == 0) ? 1'b1 : (mode == 2) ? 1'($urandom % 2) : 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      check("busy", busy, (c >= 1 && dones == 0));
      if (buf_rd_en) begin
        check("rd_addr", buf_rd_addr, AW'(base + nreads));
        check("rd_cycle", c, nreads + 1);
        nreads++;
      end
      if (m_valid) begin
        if (drain_cyc == 0) check("first_valid", c, W + 2);
        if (beats < W) begin
          for (int j = 0; j < W; j++) check("m_data", m_data[j], mem[AW'(base + j)][beats]);
        end
        check("m_last", m_last, beats == W - 1);
        drain_cyc++;
        if (m_ready) begin
          beats++;
          acc_c = c;
        end else begin
          stalls++;
        end
      end
      if (done) begin
        dones++;
        check("done_cycle", c, acc_c + 1);
        done_c = c;
      end
      if (abort_at >= 0 && beats == abort_at + 1) begin
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (done_c >= 0 && c >= done_c + 2) fin = 1;
      @(posedge clk); #1;
      start = poke && (c + 1 == 5 || c + 1 == 20);
      if (mode == 0) m_ready = 1'b1;
      else if (mode == 1) m_ready = (drain_cyc >= 5) && ((drain_cyc - 5) % 2 == 0);
      else m_ready = 1'($urandom % 2);
    end
    start = 1'b0;
    check("timeout", fin, 1'b1);
    check("num_reads", nreads, W);
    check("num_beats", beats, W);
    check("num_done", dones, 1);
`ifdef OUTPUT_DRAIN_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stalls);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_tile(10'h020, 1'b1, 0, 1'b0, -1);
    run_tile(10'h3F8, 1'b0, 0, 1'b0, -1);
    run_tile(10'h100, 1'b0, 1, 1'b0, -1);
    run_tile(10'h200, 1'b0, 2, 1'b1, -1);
    run_tile(10'h040, 1'b0, 0, 1'b0, 7);
    run_tile(10'h040, 1'b0, 0, 1'b0, -1);
    for (int t = 0; t < 4; t++) begin
      run_tile(AW'($urandom), 1'b0, int'($urandom % 3), 1'($urandom % 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
